// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light lamp monitor.
// Lamp vectors are packed as {lc,lb,la,ra,rb,rc}.
package tail_light_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_R1   = 3'd4,
        ST_R2   = 3'd5,
        ST_R3   = 3'd6,
        ST_UNK  = 3'd7
    } state_e;

    localparam logic [5:0] PAT_OFF = 6'b000_000;
    localparam logic [5:0] PAT_L1  = 6'b001_000;
    localparam logic [5:0] PAT_L2  = 6'b011_000;
    localparam logic [5:0] PAT_L3  = 6'b111_000;
    localparam logic [5:0] PAT_R1  = 6'b000_100;
    localparam logic [5:0] PAT_R2  = 6'b000_110;
    localparam logic [5:0] PAT_R3  = 6'b000_111;

    localparam logic [1:0] PH_OFF = 2'd0;
    localparam logic [1:0] PH_1   = 2'd1;
    localparam logic [1:0] PH_2   = 2'd2;
    localparam logic [1:0] PH_3   = 2'd3;

    function automatic logic [1:0] phase_of(input state_e s);
        logic [1:0] p;
        p = PH_OFF;
        case (s)
            ST_L1, ST_R1: p = PH_1;
            ST_L2, ST_R2: p = PH_2;
            ST_L3, ST_R3: p = PH_3;
            default:      p = PH_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tail_light_pattern_decode.sv
// Combinational classifier for one sampled lamp vector.
// Exactly one of is_off/is_left/is_right/illegal is set.
module tail_light_pattern_decode
    import tail_light_pkg::*;
(
    input  logic [5:0] lamps,
    output logic       is_off,
    output logic       is_left,
    output logic       is_right,
    output logic [1:0] step,
    output logic       illegal
);

    always_comb begin
        is_off   = 1'b0;
        is_left  = 1'b0;
        is_right = 1'b0;
        step     = PH_OFF;
        illegal  = 1'b0;
        unique case (1'b1)
            (lamps == PAT_OFF): is_off = 1'b1;
            (lamps == PAT_L1): begin
                is_left = 1'b1;
                step    = PH_1;
            end
            (lamps == PAT_L2): begin
                is_left = 1'b1;
                step    = PH_2;
            end
            (lamps == PAT_L3): begin
                is_left = 1'b1;
                step    = PH_3;
            end
            (lamps == PAT_R1): begin
                is_right = 1'b1;
                step     = PH_1;
            end
            (lamps == PAT_R2): begin
                is_right = 1'b1;
                step     = PH_2;
            end
            (lamps == PAT_R3): begin
                is_right = 1'b1;
                step     = PH_3;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tail_light_monitor.sv
// Passive checker for the TailLight sequencer lamp bus: tracks
// left/right sweeps and counts completed sweeps and violations.
module tail_light_monitor
    import tail_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic             active_left,
    output logic             active_right,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             abort,
    output logic             err,
    output logic [CNT_W-1:0] seq_count,
    output logic [CNT_W-1:0] err_count
);

    logic [5:0] lamps;
    logic       is_off;
    logic       is_left;
    logic       is_right;
    logic [1:0] step;
    logic       illegal;

    assign lamps = {lc, lb, la, ra, rb, rc};

    tail_light_pattern_decode u_dec (
        .lamps    (lamps),
        .is_off   (is_off),
        .is_left  (is_left),
        .is_right (is_right),
        .step     (step),
        .illegal  (illegal)
    );

    logic l_at1, l_at2, l_at3;
    logic r_at1, r_at2, r_at3;

    assign l_at1 = is_left  && (step == PH_1);
    assign l_at2 = is_left  && (step == PH_2);
    assign l_at3 = is_left  && (step == PH_3);
    assign r_at1 = is_right && (step == PH_1);
    assign r_at2 = is_right && (step == PH_2);
    assign r_at3 = is_right && (step == PH_3);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic             act_l_q, act_r_q;
    logic [1:0]       phase_q;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_off)     state_d = ST_IDLE;
                else if (l_at1) state_d = ST_L1;
                else if (r_at1) state_d = ST_R1;
                else            err_d   = 1'b1;
            end
            ST_L1, ST_L2: begin
                if (is_off) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (state_q == ST_L1 && l_at2) begin
                    state_d = ST_L2;
                end else if (state_q == ST_L2 && l_at3) begin
                    state_d = ST_L3;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_R1, ST_R2: begin
                if (is_off) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (state_q == ST_R1 && r_at2) begin
                    state_d = ST_R2;
                end else if (state_q == ST_R2 && r_at3) begin
                    state_d = ST_R3;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_L3, ST_R3: begin
                done_d = 1'b1;
                if (is_off)     state_d = ST_IDLE;
                else if (l_at1) state_d = ST_L1;
                else if (r_at1) state_d = ST_R1;
                else begin
                    done_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            default: begin
                if (is_off) state_d = ST_IDLE;
            end
        endcase
        // Violations resync on a sweep start; anything else is lost.
        if (err_d) begin
            if (l_at1)      state_d = ST_L1;
            else if (r_at1) state_d = ST_R1;
            else            state_d = ST_UNK;
        end
    end

    always_comb begin
        seq_cnt_d = seq_cnt_q;
        err_cnt_d = err_cnt_q;
        if (done_d) seq_cnt_d = seq_cnt_q + 1'b1;
        if (err_d && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
            act_l_q   <= 1'b0;
            act_r_q   <= 1'b0;
            phase_q   <= PH_OFF;
            seq_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
            act_l_q   <= (state_d == ST_L1) || (state_d == ST_L2)
                      || (state_d == ST_L3);
            act_r_q   <= (state_d == ST_R1) || (state_d == ST_R2)
                      || (state_d == ST_R3);
            phase_q   <= phase_of(state_d);
            seq_cnt_q <= seq_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign active_left  = act_l_q;
    assign active_right = act_r_q;
    assign phase        = phase_q;
    assign seq_done     = done_q;
    assign abort        = abort_q;
    assign err          = err_q;
    assign seq_count    = seq_cnt_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Self-checking bench for tail_light_monitor: directed table,
// randomized run against a sweep-level model, and corner sequences.
module tb_tail_light_monitor;

    logic       clock;
    logic       reset;
    logic       la, lb, lc, ra, rb, rc;
    logic       active_left, active_right;
    logic [1:0] phase;
    logic       seq_done, abort, err;
    logic [7:0] seq_count, err_count;

    tail_light_monitor #(.CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .la           (la),
        .lb           (lb),
        .lc           (lc),
        .ra           (ra),
        .rb           (rb),
        .rc           (rc),
        .active_left  (active_left),
        .active_right (active_right),
        .phase        (phase),
        .seq_done     (seq_done),
        .abort        (abort),
        .err          (err),
        .seq_count    (seq_count),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [5:0] OFF = 6'b000000;
    localparam logic [5:0] L1  = 6'b001000;
    localparam logic [5:0] L2  = 6'b011000;
    localparam logic [5:0] L3  = 6'b111000;
    localparam logic [5:0] R1  = 6'b000100;
    localparam logic [5:0] R2  = 6'b000110;
    localparam logic [5:0] R3  = 6'b000111;
    localparam logic [5:0] LAR = 6'b001100;
    localparam logic [5:0] ALL = 6'b111111;

    int total = 0;
    int bad   = 0;

    // Model: side 0 = idle, 1 = left, 2 = right, 3 = lost.
    int m_side, m_step, m_seq, m_errc;
    int m_done, m_abort, m_err;
    logic [5:0] legal [7];

    initial begin
        legal[0] = OFF; legal[1] = L1; legal[2] = L2; legal[3] = L3;
        legal[4] = R1;  legal[5] = R2; legal[6] = R3;
    end

    task automatic model_reset();
        m_side = 0; m_step = 0; m_seq = 0; m_errc = 0;
        m_done = 0; m_abort = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [5:0] v);
        int idx, side, st;
        idx = -1;
        for (int i = 0; i < 7; i++) if (legal[i] == v) idx = i;
        side = (idx <= 0) ? 0 : ((idx <= 3) ? 1 : 2);
        st   = (idx <= 0) ? 0 : ((idx - 1) % 3 + 1);
        m_done = 0; m_abort = 0; m_err = 0;
        if (m_side == 3) begin
            if (idx == 0) m_side = 0;
        end else if (idx == 0) begin
            if (m_step == 3) m_done = 1;
            else if (m_step > 0) m_abort = 1;
            m_side = 0; m_step = 0;
        end else if (idx > 0 && side == m_side && st == m_step + 1) begin
            m_step = st;
        end else if (idx > 0 && st == 1 && (m_step == 0 || m_step == 3)) begin
            if (m_step == 3) m_done = 1;
            m_side = side; m_step = 1;
        end else begin
            m_err = 1;
            if (idx > 0 && st == 1) begin
                m_side = side; m_step = 1;
            end else begin
                m_side = 3; m_step = 0;
            end
        end
        if (m_done) m_seq = (m_seq + 1) % 256;
        if (m_err && m_errc < 255) m_errc++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int ph;
        ph = (m_side == 3) ? 0 : m_step;
        chk({tag, " phase"}, int'(phase), ph);
        chk({tag, " act_l"}, int'(active_left), int'(m_side == 1));
        chk({tag, " act_r"}, int'(active_right), int'(m_side == 2));
        chk({tag, " done"}, int'(seq_done), m_done);
        chk({tag, " abort"}, int'(abort), m_abort);
        chk({tag, " err"}, int'(err), m_err);
        chk({tag, " seq_cnt"}, int'(seq_count), m_seq);
        chk({tag, " err_cnt"}, int'(err_count), m_errc);
    endtask

    task automatic apply(input logic [5:0] v);
        {lc, lb, la, ra, rb, rc} = v;
        @(posedge clock);
        #1;
        model_step(v);
    endtask

    typedef struct {
        logic [5:0] v;
        int ph, al, ar, dn, ab, er;
    } vec_t;

    vec_t tbl [34];

    task automatic set(input int i, input logic [5:0] v, input int ph,
                       input int al, input int ar, input int dn,
                       input int ab, input int er);
        tbl[i].v = v; tbl[i].ph = ph; tbl[i].al = al; tbl[i].ar = ar;
        tbl[i].dn = dn; tbl[i].ab = ab; tbl[i].er = er;
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  v;

        set(0,  OFF, 0, 0, 0, 0, 0, 0);
        set(1,  OFF, 0, 0, 0, 0, 0, 0);
        set(2,  L1,  1, 1, 0, 0, 0, 0);
        set(3,  L2,  2, 1, 0, 0, 0, 0);
        set(4,  L3,  3, 1, 0, 0, 0, 0);
        set(5,  OFF, 0, 0, 0, 1, 0, 0);
        set(6,  L1,  1, 1, 0, 0, 0, 0);
        set(7,  L2,  2, 1, 0, 0, 0, 0);
        set(8,  L3,  3, 1, 0, 0, 0, 0);
        set(9,  L1,  1, 1, 0, 1, 0, 0);
        set(10, L2,  2, 1, 0, 0, 0, 0);
        set(11, L3,  3, 1, 0, 0, 0, 0);
        set(12, OFF, 0, 0, 0, 1, 0, 0);
        set(13, R1,  1, 0, 1, 0, 0, 0);
        set(14, R2,  2, 0, 1, 0, 0, 0);
        set(15, R3,  3, 0, 1, 0, 0, 0);
        set(16, OFF, 0, 0, 0, 1, 0, 0);
        set(17, R1,  1, 0, 1, 0, 0, 0);
        set(18, R2,  2, 0, 1, 0, 0, 0);
        set(19, OFF, 0, 0, 0, 0, 1, 0);
        set(20, L1,  1, 1, 0, 0, 0, 0);
        set(21, L2,  2, 1, 0, 0, 0, 0);
        set(22, OFF, 0, 0, 0, 0, 1, 0);
        set(23, LAR, 0, 0, 0, 0, 0, 1);
        set(24, L2,  0, 0, 0, 0, 0, 0);
        set(25, OFF, 0, 0, 0, 0, 0, 0);
        set(26, L1,  1, 1, 0, 0, 0, 0);
        set(27, L3,  0, 0, 0, 0, 0, 1);
        set(28, OFF, 0, 0, 0, 0, 0, 0);
        set(29, R1,  1, 0, 1, 0, 0, 0);
        set(30, R1,  1, 0, 1, 0, 0, 1);
        set(31, R2,  2, 0, 1, 0, 0, 0);
        set(32, L1,  1, 1, 0, 0, 0, 1);
        set(33, OFF, 0, 0, 0, 0, 1, 0);

        {lc, lb, la, ra, rb, rc} = OFF;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_model("in_reset");
        reset = 1'b1;
        apply(OFF);
        chk_model("post_reset");

        for (int i = 0; i < 34; i++) begin
            string t;
            t = $sformatf("row%0d", i);
            apply(tbl[i].v);
            chk({t, " phase"}, int'(phase), tbl[i].ph);
            chk({t, " act_l"}, int'(active_left), tbl[i].al);
            chk({t, " act_r"}, int'(active_right), tbl[i].ar);
            chk({t, " done"}, int'(seq_done), tbl[i].dn);
            chk({t, " abort"}, int'(abort), tbl[i].ab);
            chk({t, " err"}, int'(err), tbl[i].er);
            chk({t, " seq_cnt"}, int'(seq_count), m_seq);
            chk({t, " err_cnt"}, int'(err_count), m_errc);
        end
        chk("table seq_total", int'(seq_count), 4);
        chk("table err_total", int'(err_count), 4);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if (r[31:29] == 3'd0) v = r[5:0];
            else v = legal[r[10:8] % 7];
            apply(v);
            chk_model($sformatf("rnd%0d", i));
        end

        apply(OFF);
        apply(OFF);
        for (int i = 0; i < 300; i++) begin
            apply(ALL);
            chk_model($sformatf("sat_e%0d", i));
            apply(OFF);
            chk_model($sformatf("sat_o%0d", i));
        end
        chk("sat err_cnt", int'(err_count), 255);

        apply(L1);
        apply(L2);
        chk("preL2 phase", int'(phase), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst phase", int'(phase), 0);
        chk("arst act_l", int'(active_left), 0);
        chk("arst act_r", int'(active_right), 0);
        chk("arst pulses", int'({seq_done, abort, err}), 0);
        chk("arst seq_cnt", int'(seq_count), 0);
        chk("arst err_cnt", int'(err_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        apply(L3);
        chk_model("rel_L3");
        chk("rel_L3 err", int'(err), 1);
        apply(L2);
        chk_model("rel_unk");
        apply(OFF);
        chk_model("rel_off");
        apply(R1);
        chk_model("rel_r1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tail_light_monitor.md
Name: tail_light_monitor

Overview:
- Receiver/checker for the six tail-light lamp lines driven by the TailLight sequencer.
- Samples the lamp vector every clock, decodes it into direction and phase, and tracks the expected left/right sweep sequence.
- Flags completed sweeps, aborted sweeps and protocol violations, and keeps counters for each.
- Sits on the lamp bus as a passive observer, for on-chip self-check and bench scoreboarding.

Parameters:
CNT_W, 8, width of seq_count and err_count.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
la  in  1  left lamp A (innermost)
lb  in  1  left lamp B
lc  in  1  left lamp C (outermost)
ra  in  1  right lamp A (innermost)
rb  in  1  right lamp B
rc  in  1  right lamp C (outermost)
active_left  out  1  monitor is in L1, L2 or L3
active_right  out  1  monitor is in R1, R2 or R3
phase  out  2  0 = off/unknown, 1..3 = sweep step
seq_done  out  1  one-cycle pulse when a sweep completes legally
abort  out  1  one-cycle pulse when a sweep ends early to all-off
err  out  1  one-cycle pulse on a protocol violation
seq_count  out  CNT_W  completed sweeps; wraps modulo 2^CNT_W
err_count  out  CNT_W  violations; saturates at all-ones

Behaviour:
- Lamp inputs are synchronous to clock; there is no synchronizer.
- Legal patterns:
  - OFF = all zero.
  - L1 = la; L2 = la,lb; L3 = la,lb,lc (right lamps zero).
  - R1, R2, R3 mirror L1..L3 on ra, rb, rc (left lamps zero).
  - Any other vector is ILLEGAL.
- States: IDLE, L1, L2, L3, R1, R2, R3, UNK. All outputs are registered.
- Latency: the pattern present at rising edge k updates state and outputs at edge k; they are visible in the cycle after edge k.
- Transitions (current state, sampled pattern -> next state, pulse):
  - IDLE: OFF -> IDLE; L1 -> L1; R1 -> R1; anything else -> err.
  - L1: L2 -> L2. L2: L3 -> L3.
  - L1 or L2: OFF -> IDLE with abort (no err).
  - L1 or L2: holding the same pattern -> err.
  - L3: OFF -> IDLE, L1 -> L1, R1 -> R1; each with seq_done and seq_count+1. Back-to-back sweeps are legal.
  - R-side rules mirror the L-side rules.
  - UNK: OFF -> IDLE with no pulse; any other pattern stays in UNK with no further err.
- On err, resync:
  - Sampled OFF -> IDLE.
  - Sampled L1 or R1 -> L1 or R1.
  - Any other pattern -> UNK.
- Examples of err: L1->L3, L2->L1, L2->R2, L3->L3, any ILLEGAL vector.
- err_count increments on each err pulse and holds at 2^CNT_W-1.
- seq_done, abort and err are mutually exclusive within a cycle.
- phase and active_* reflect the next state; UNK and IDLE give phase 0 and both active_* low.
- Reset (async assert, sync release): state IDLE, all outputs 0, both counters 0. Reset mid-sweep discards the sweep with no pulse.
- After release, a lamp vector of L2 or L3 is an err leading to UNK.

Decomposition:
- Package tail_light_pkg:
  - State enum.
  - Lamp pattern constants PAT_OFF, PAT_L1..PAT_L3, PAT_R1..PAT_R3, packed as {lc,lb,la,ra,rb,rc}.
  - Phase constants.
- Sub-module tail_light_pattern_decode: combinational classifier, 6-bit vector in; outputs is_off, is_left, is_right, step[1:0], illegal.
- The monitor holds the FSM, pulse generation and counters.

Test Plan:
- Reset low then high, lamps OFF for 3 cycles -> all outputs 0, phase 0.
- Sequence OFF,L1,L2,L3,OFF -> phase 1,2,3,0; active_left high for 3 cycles; seq_done pulses once; seq_count=1; err_count=0.
- Left held: L1,L2,L3,L1,L2,L3,OFF -> seq_done pulses twice; seq_count=2; no err. Then R1,R2,R3,OFF -> active_right for 3 cycles; seq_count=3.
- R1,R2,OFF -> abort pulses once; seq_count unchanged; err_count=0. Repeat on the left side with the same result.
- Vector la+ra (ILLEGAL), then L2, then OFF -> err one cycle; state UNK, phase 0; no second err; IDLE after OFF; err_count=1.
- Force 300 ILLEGAL-entry events with CNT_W=8 -> err_count saturates at 255. Assert reset while in L2 -> outputs 0 immediately, without a clock.
